// File: rtl/mixed_radix_add_stage.sv
`default_nettype none
// ============================================================================
// Module      : mixed_radix_add_stage
// Description : Clocked 1-of-RA + 1-of-RB digit adder on a four-phase
//               DATA/NULL handshake, with sticky illegal-code flag and a
//               completed-wavefront counter.
// Revision    : 1.0  initial release
// ============================================================================
module mixed_radix_add_stage #(
    parameter int RA    = 2,
    parameter int RB    = 3,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                init_n,
    input  logic [RA-1:0]       a_rail,
    input  logic [RB-1:0]       b_rail,
    input  logic                out_ack,
    output logic [RA+RB-2:0]    q_rail,
    output logic                in_ack,
    output logic                err,
    output logic [CNT_W-1:0]    wave_cnt
);

    localparam int QW = RA + RB - 1;

    localparam logic [RA-1:0]    C_A_ONE   = RA'(1);
    localparam logic [RB-1:0]    C_B_ONE   = RB'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        HOLD_NULL = 1'b0,
        HOLD_DATA = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [QW-1:0]    r_q;
    logic [QW-1:0]    w_q_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_a_null;
    logic             w_a_multi;
    logic             w_a_data;
    logic             w_b_null;
    logic             w_b_multi;
    logic             w_b_data;
    logic             w_illegal;
    logic             w_enable;
    logic [QW-1:0]    w_sum;

    // x & (x-1) clears the lowest set bit, so it is non-zero only when
    // two or more rails are high.
    assign w_a_null  = ~|a_rail;
    assign w_a_multi = |(a_rail & (a_rail - C_A_ONE));
    assign w_a_data  = ~w_a_null & ~w_a_multi;
    assign w_b_null  = ~|b_rail;
    assign w_b_multi = |(b_rail & (b_rail - C_B_ONE));
    assign w_b_data  = ~w_b_null & ~w_b_multi;
    assign w_illegal = w_a_multi | w_b_multi;
    assign w_enable  = ~out_ack;

    // Rail-level sum: with both operands one-hot exactly one product term
    // fires, landing on rail a+b, so no binary encode/decode is needed.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < RA; i++) begin
            for (int j = 0; j < RB; j++) begin
                w_sum[i+j] = w_sum[i+j] | (a_rail[i] & b_rail[j]);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err | w_illegal;
        case (r_state)
            HOLD_NULL: begin
                if (!w_illegal && w_enable && w_a_data && w_b_data) begin
                    w_q_nxt     = w_sum;
                    w_state_nxt = HOLD_DATA;
                end
            end
            HOLD_DATA: begin
                if (!w_illegal && out_ack && w_a_null && w_b_null) begin
                    w_q_nxt     = '0;
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                    w_state_nxt = HOLD_NULL;
                end
            end
            default: begin
                w_q_nxt     = '0;
                w_state_nxt = HOLD_NULL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state <= HOLD_NULL;
            r_q     <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign q_rail   = r_q;
    assign in_ack   = (r_state == HOLD_DATA);
    assign err      = r_err;
    assign wave_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mixed_radix_add_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mixed_radix_add_stage
// Description : Directed bench for mixed_radix_add_stage, default radices and
//               an RA=4/RB=5/CNT_W=3 instance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mixed_radix_add_stage;

    logic        clk;
    logic        init_n;
    logic [1:0]  a_rail;
    logic [2:0]  b_rail;
    logic        out_ack;
    logic [3:0]  q_rail;
    logic        in_ack;
    logic        err;
    logic [15:0] wave_cnt;

    logic [3:0]  g_a_rail;
    logic [4:0]  g_b_rail;
    logic        g_out_ack;
    logic [7:0]  g_q_rail;
    logic        g_in_ack;
    logic        g_err;
    logic [2:0]  g_wave_cnt;

    int errors = 0;
    int checks = 0;

    mixed_radix_add_stage dut (
        .clk      (clk),
        .init_n   (init_n),
        .a_rail   (a_rail),
        .b_rail   (b_rail),
        .out_ack  (out_ack),
        .q_rail   (q_rail),
        .in_ack   (in_ack),
        .err      (err),
        .wave_cnt (wave_cnt)
    );

    mixed_radix_add_stage #(.RA(4), .RB(5), .CNT_W(3)) dut_g (
        .clk      (clk),
        .init_n   (init_n),
        .a_rail   (g_a_rail),
        .b_rail   (g_b_rail),
        .out_ack  (g_out_ack),
        .q_rail   (g_q_rail),
        .in_ack   (g_in_ack),
        .err      (g_err),
        .wave_cnt (g_wave_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full four-phase wavefront on the default instance.
    task automatic wave(input logic [1:0] a, input logic [2:0] b,
                        input logic [3:0] exp_q, input string tag);
        a_rail  = a;
        b_rail  = b;
        out_ack = 1'b0;
        tick();
        chk({tag, "_q"}, 32'(q_rail), 32'(exp_q));
        chk({tag, "_ack"}, 32'(in_ack), 32'd1);
        out_ack = 1'b1;
        tick();
        chk({tag, "_hold"}, 32'(q_rail), 32'(exp_q));
        a_rail = '0;
        b_rail = '0;
        tick();
        chk({tag, "_null"}, 32'(q_rail), 32'd0);
        chk({tag, "_ack0"}, 32'(in_ack), 32'd0);
        out_ack = 1'b0;
    endtask

    initial begin
        init_n    = 1'b0;
        a_rail    = '0;
        b_rail    = '0;
        out_ack   = 1'b0;
        g_a_rail  = '0;
        g_b_rail  = '0;
        g_out_ack = 1'b0;
        #12;
        chk("rst_q", 32'(q_rail), 32'd0);
        chk("rst_ack", 32'(in_ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(wave_cnt), 32'd0);
        chk("rst_gq", 32'(g_q_rail), 32'd0);
        init_n = 1'b1;
        tick();

        // Asynchronous reset while holding DATA a=1, b=2.
        a_rail = 2'b10;
        b_rail = 3'b100;
        tick();
        chk("mid_q", 32'(q_rail), 32'h8);
        chk("mid_ack", 32'(in_ack), 32'd1);
        #2;
        init_n = 1'b0;
        #1;
        chk("async_q", 32'(q_rail), 32'd0);
        chk("async_ack", 32'(in_ack), 32'd0);
        chk("async_cnt", 32'(wave_cnt), 32'd0);
        a_rail = '0;
        b_rail = '0;
        #1;
        init_n = 1'b1;
        tick();

        // Full sweep of all six operand pairs.
        wave(2'b01, 3'b001, 4'b0001, "s00");
        wave(2'b01, 3'b010, 4'b0010, "s01");
        wave(2'b01, 3'b100, 4'b0100, "s02");
        wave(2'b10, 3'b001, 4'b0010, "s10");
        wave(2'b10, 3'b010, 4'b0100, "s11");
        // Last pair also checks that operand changes in HOLD_DATA are ignored.
        a_rail = 2'b10;
        b_rail = 3'b100;
        tick();
        chk("s12_q", 32'(q_rail), 32'h8);
        a_rail = 2'b01;
        b_rail = 3'b001;
        tick();
        chk("s12_chg", 32'(q_rail), 32'h8);
        out_ack = 1'b1;
        a_rail  = '0;
        b_rail  = '0;
        tick();
        chk("s12_null", 32'(q_rail), 32'd0);
        out_ack = 1'b0;
        chk("sweep_cnt", 32'(wave_cnt), 32'd6);

        // Partial completeness: only A present.
        a_rail = 2'b10;
        b_rail = 3'b000;
        repeat (5) tick();
        chk("part_q", 32'(q_rail), 32'd0);
        chk("part_ack", 32'(in_ack), 32'd0);
        b_rail = 3'b001;
        tick();
        chk("part_cap", 32'(q_rail), 32'h2);
        out_ack = 1'b1;
        a_rail  = '0;
        b_rail  = '0;
        tick();
        out_ack = 1'b0;
        chk("part_cnt", 32'(wave_cnt), 32'd7);

        // Backpressure: consumer still holding DATA.
        out_ack = 1'b1;
        a_rail  = 2'b01;
        b_rail  = 3'b010;
        repeat (4) tick();
        chk("bp_q", 32'(q_rail), 32'd0);
        chk("bp_ack", 32'(in_ack), 32'd0);
        out_ack = 1'b0;
        tick();
        chk("bp_cap", 32'(q_rail), 32'h2);
        out_ack = 1'b1;
        a_rail  = '0;
        b_rail  = '0;
        tick();
        out_ack = 1'b0;
        chk("bp_cnt", 32'(wave_cnt), 32'd8);

        // Illegal code on B with DATA on A.
        chk("ill_pre", 32'(err), 32'd0);
        a_rail = 2'b01;
        b_rail = 3'b011;
        tick();
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_q", 32'(q_rail), 32'd0);
        chk("ill_ack", 32'(in_ack), 32'd0);
        wave(2'b01, 3'b001, 4'b0001, "ill_w");
        chk("ill_sticky", 32'(err), 32'd1);
        chk("ill_cnt", 32'(wave_cnt), 32'd9);

        init_n = 1'b0;
        #1;
        chk("ill_rst", 32'(err), 32'd0);
        init_n = 1'b1;
        tick();

        // Illegal code arriving while DATA is held.
        a_rail = 2'b10;
        b_rail = 3'b010;
        tick();
        chk("hd_q", 32'(q_rail), 32'h4);
        out_ack = 1'b1;
        b_rail  = 3'b110;
        tick();
        chk("hd_err", 32'(err), 32'd1);
        chk("hd_hold", 32'(q_rail), 32'h4);
        a_rail = '0;
        b_rail = '0;
        tick();
        chk("hd_null", 32'(q_rail), 32'd0);
        out_ack = 1'b0;

        // Generalised radix: a=3, b=4 lands on rail 7; counter wraps at 8.
        for (int n = 1; n <= 9; n++) begin
            g_a_rail  = 4'b1000;
            g_b_rail  = 5'b10000;
            g_out_ack = 1'b0;
            tick();
            chk("g_q", 32'(g_q_rail), 32'h80);
            g_out_ack = 1'b1;
            g_a_rail  = '0;
            g_b_rail  = '0;
            tick();
            g_out_ack = 1'b0;
            if (n == 7) chk("g_cnt7", 32'(g_wave_cnt), 32'd7);
            if (n == 8) chk("g_wrap", 32'(g_wave_cnt), 32'd0);
        end
        chk("g_cnt9", 32'(g_wave_cnt), 32'd1);
        chk("g_err", 32'(g_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mixed_radix_add_stage.md
Name: mixed_radix_add_stage

Overview:
- Parametrised, clocked successor to the binary+trinary=quaternary NCL adder.
- Adds one 1-of-RA dual-rail-style digit and one 1-of-RB digit. Produces a registered 1-of-(RA+RB-1) sum digit.
- Uses the NCL four-phase DATA/NULL wavefront handshake with completion signalling on both sides.
- Adds behaviour the original lacks: arbitrary radices, illegal-code detection with a sticky error, and a completed-wavefront counter.
- Sits between mixed-radix producer rings and any 1-of-N consumer, for example the quaternary auto-consume completion.

Parameters:
- RA, 2, radix of operand A (number of A rails); must be >= 2.
- RB, 3, radix of operand B (number of B rails); must be >= 2.
- CNT_W, 16, width of the completed-wavefront counter.

Ports:
- clk  input  1  stage clock; all state updates on the rising edge.
- init_n  input  1  asynchronous, active-low reset.
- a_rail  input  RA  operand A. One-hot means DATA of value index; all-zero means NULL.
- b_rail  input  RB  operand B, same encoding as a_rail.
- out_ack  input  1  consumer completion. 1 = consumer holds DATA and requests NULL; 0 = consumer holds NULL and requests DATA.
- q_rail  output  RA+RB-1  sum digit. One-hot at index a+b when DATA; all-zero when NULL.
- in_ack  output  1  completion to producers. 1 = stage holds DATA; 0 = stage holds NULL.
- err  output  1  sticky illegal-code flag.
- wave_cnt  output  CNT_W  number of completed DATA->NULL wavefronts.

Behaviour:
- Reset (init_n=0, asynchronous, any time including mid-wavefront):
  - q_rail=0, in_ack=0, err=0, wave_cnt=0, state=HOLD_NULL.
  - Takes effect immediately, without waiting for a clock edge.
  - Normal operation resumes on the first rising clk edge after init_n goes high.
- Input classification, each cycle, per operand:
  - NULL: all rails 0.
  - DATA: exactly one rail 1.
  - ILLEGAL: two or more rails 1.
- Enable = ~out_ack. This is the clocked equivalent of the THnotN gate in the NCL stage.
- State HOLD_NULL (q_rail=0, in_ack=0):
  - Transition: if enable=1 and both operands are DATA, then at the next edge q_rail=one-hot(a+b), in_ack=1, and the state goes to HOLD_DATA. Latency is 1 clock.
  - Hold cases: one operand DATA and the other NULL, or enable=0. State holds; q_rail stays 0.
- State HOLD_DATA (q_rail holds the sum, in_ack=1):
  - Transition: if out_ack=1 and both operands are NULL, then at the next edge q_rail=0, in_ack=0, wave_cnt+=1, and the state goes to HOLD_NULL.
  - Partial NULL (one operand still DATA): hold.
  - Operand value changing while in HOLD_DATA: ignored. q_rail stays latched to the captured value.
- Arithmetic:
  - Sum index = a+b, range 0..RA+RB-2. Overflow is impossible by construction.
  - q_rail has exactly one rail set in DATA.
- Illegal codes:
  - Any ILLEGAL operand sets err=1 at the next edge.
  - That cycle is treated as incomplete: no state change.
  - err clears only on reset.
- Simultaneous events:
  - ILLEGAL on one operand and DATA on the other in HOLD_NULL: err sets, no capture.
  - ILLEGAL during HOLD_DATA: err sets, q_rail holds.
- Counter: wave_cnt wraps modulo 2^CNT_W, from 2^CNT_W-1 to 0, with no flag.
- NULL/DATA alternation is strictly enforced. Two DATA wavefronts can never be captured without an intervening NULL.

Test Plan:
- Reset mid-DATA: hold a=1, b=2 in HOLD_DATA, pulse init_n low between edges -> q_rail=0000, in_ack=0, wave_cnt=0 immediately, before the next clk.
- Default radices, full sweep: all 6 (a,b) pairs, four-phase with auto-consume (out_ack = OR of q_rail, one cycle late) -> q_rail index = a+b; after a=1, b=2, q_rail=1000; wave_cnt=6 at the end.
- Partial completeness: a=1 DATA, b=NULL for 5 cycles -> q_rail=0, in_ack=0; then b=0 -> q_rail=0010 one edge later.
- Backpressure: both operands DATA but out_ack held 1 for 4 cycles -> no capture; out_ack drops to 0 -> capture on the next edge.
- Illegal code: b_rail=011 -> err=1 at the next edge, no capture; err stays 1 through further legal wavefronts until reset.
- Generalised radix and wrap: RA=4, RB=5, CNT_W=3, a=3, b=4 -> q_rail bit 7 set (8-bit output); 9 wavefronts -> wave_cnt=1.
